// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the NoC output-port allocator: FSM state encoding
// and default sizing parameters.
package noc_alloc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_RELEASE = 2'd2
  } alloc_state_e;

  localparam int DEF_INPORTS         = 4;
  localparam int DEF_MAX_LOCK_CYCLES = 16;

endpackage

// File: rtl/outport_allocator_if.sv
// Request/grant bundle between the input ports and one output-port allocator.
// The master side is the set of requesting inputs; the slave side is the allocator.
interface outport_allocator_if
  import noc_alloc_pkg::*;
#(
  parameter int INPORTS = DEF_INPORTS
);
  localparam int IW = $clog2(INPORTS);

  logic [INPORTS-1:0] req_i;
  logic [INPORTS-1:0] tail_passed_i;
  logic               out_ready_i;
  logic [INPORTS-1:0] grant_o;
  logic [IW-1:0]      owner_o;
  logic               busy_o;
  logic               timeout_err_o;

  modport master (
    output req_i, tail_passed_i, out_ready_i,
    input  grant_o, owner_o, busy_o, timeout_err_o
  );

  modport slave (
    input  req_i, tail_passed_i, out_ready_i,
    output grant_o, owner_o, busy_o, timeout_err_o
  );
endinterface

// File: rtl/rr_pick.sv
// Stateless round-robin picker: first set request at or above ptr_i, wrapping
// from N-1 back to 0.
module rr_pick
  import noc_alloc_pkg::*;
#(
  parameter int N  = DEF_INPORTS,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // w_cand[gi] is the input index examined at search offset gi.
  logic [IW-1:0] w_cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] w_sum;
      assign w_sum       = {1'b0, ptr_i} + (IW+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[w_cand[k]]) begin
        valid_o = 1'b1;
        idx_o   = w_cand[k];
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/outport_allocator.sv
// Output-port allocator: locks the port to one input per packet, releases on
// the owner's tail or a watchdog expiry, and rotates priority round-robin.
module outport_allocator
  import noc_alloc_pkg::*;
#(
  parameter int INPORTS         = DEF_INPORTS,
  parameter int MAX_LOCK_CYCLES = DEF_MAX_LOCK_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  outport_allocator_if.slave  bus
);

  localparam int IW = $clog2(INPORTS);
  localparam int CW = (MAX_LOCK_CYCLES > 1) ? $clog2(MAX_LOCK_CYCLES) : 1;

  alloc_state_e       r_state;
  logic [INPORTS-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_timeout;

  logic [INPORTS-1:0] w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_owner_tail;
  logic               w_expire;

  rr_pick #(.N(INPORTS)) u_rr_pick (
    .req_i    (bus.req_i),
    .ptr_i    (r_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .valid_o  (w_pick_valid)
  );

  // Only the owner's tail matters; other inputs' tail pulses are ignored.
  assign w_owner_tail = bus.tail_passed_i[r_owner];
  assign w_expire     = (r_cnt == CW'(MAX_LOCK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.out_ready_i && w_pick_valid) begin
            r_state <= ST_LOCKED;
            r_grant <= w_pick_onehot;
            r_owner <= w_pick_idx;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // A real tail wins over a simultaneous watchdog expiry.
          if (w_owner_tail || w_expire) begin
            r_state <= ST_RELEASE;
            r_grant <= '0;
            r_ptr   <= (r_owner == IW'(INPORTS - 1)) ? '0 : r_owner + IW'(1);
            if (!w_owner_tail) r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_o       = r_grant;
  assign bus.owner_o       = r_owner;
  assign bus.busy_o        = r_busy;
  assign bus.timeout_err_o = r_timeout;

endmodule

// File: tb/tb_outport_allocator.sv
// Scoreboard bench for outport_allocator: a packet-level reference model
// predicts outputs per cycle, a separate monitor compares them after each edge.
module tb_outport_allocator;
  import noc_alloc_pkg::*;

  localparam int N    = 4;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  outport_allocator_if #(.INPORTS(N)) bus ();

  outport_allocator #(.INPORTS(N), .MAX_LOCK_CYCLES(MAXL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] grant;
    int           owner;
    logic         busy;
    logic         terr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  // Reference model: which input holds the port, for how long, and whether the
  // mandatory one-cycle gap after a packet is still pending.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_age    = 0;
  int m_gap    = 0;
  bit m_err    = 0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, n_cycle, act, req);
    end
  endfunction

  task automatic end_packet(input bit expired);
    m_locked = 0;
    m_gap    = 1;
    m_ptr    = (m_owner + 1) % N;
    if (expired) m_err = 1;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] req,
                      input logic [N-1:0] tail, input logic rdy);
    exp_t e;
    bit   found;
    @(negedge clk);
    reset             = rst;
    bus.req_i         = req;
    bus.tail_passed_i = tail;
    bus.out_ready_i   = rdy;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_gap = 0; m_err = 0;
    end else if (m_locked) begin
      if (tail[m_owner])          end_packet(0);
      else if (m_age == MAXL - 1) end_packet(1);
      else                        m_age++;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (rdy && req != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found    = 1;
          m_owner  = (m_ptr + k) % N;
        end
      end
      m_locked = 1;
      m_age    = 0;
    end
    e.grant = m_locked ? N'(1 << m_owner) : '0;
    e.owner = m_owner;
    e.busy  = m_locked || (m_gap > 0);
    e.terr  = m_err;
    sb.push_back(e);
  endtask

  task automatic hold(input int n, input logic [N-1:0] req,
                      input logic [N-1:0] tail, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, req, tail, rdy);
  endtask

  // Monitor: one comparison set per edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cycle++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("cyc %0d rst=%b req=%b tail=%b rdy=%b grant=%b owner=%0d busy=%b terr=%b",
                 n_cycle, reset, bus.req_i, bus.tail_passed_i, bus.out_ready_i,
                 bus.grant_o, bus.owner_o, bus.busy_o, bus.timeout_err_o);
        chk("grant", int'(bus.grant_o), int'(e.grant));
        chk("owner", int'(bus.owner_o), e.owner);
        chk("busy", int'(bus.busy_o), int'(e.busy));
        chk("timeout_err", int'(bus.timeout_err_o), int'(e.terr));
        chk("onehot", ($countones(bus.grant_o) <= 1) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    logic [N-1:0] r_req, r_tail;
    reset             = 1'b1;
    bus.req_i         = '0;
    bus.tail_passed_i = '0;
    bus.out_ready_i   = 1'b0;

    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, 4'b0000, 1'b1);
    // First grant after reset goes to input 1, then tail hands over to input 3.
    hold(4, 4'b1010, 4'b0000, 1'b1);
    hold(1, 4'b1010, 4'b0010, 1'b1);
    hold(4, 4'b1010, 4'b0000, 1'b1);
    hold(1, 4'b0000, 4'b1000, 1'b1);
    hold(3, 4'b0000, 4'b0000, 1'b1);
    // Lock input 2; foreign tail bits and changing requests must not disturb it.
    hold(1, 4'b0100, 4'b0000, 1'b1);
    hold(1, 4'b1011, 4'b0001, 1'b0);
    hold(1, 4'b0001, 4'b1011, 1'b1);
    hold(1, 4'b1111, 4'b0001, 1'b1);
    hold(1, 4'b0100, 4'b0100, 1'b1);
    hold(2, 4'b0000, 4'b0000, 1'b1);
    // Watchdog: input 0 holds without a tail until expiry; flag stays sticky.
    hold(1, 4'b0001, 4'b0000, 1'b1);
    hold(24, 4'b0000, 4'b0000, 1'b1);
    hold(1, 4'b0010, 4'b0000, 1'b1);
    hold(3, 4'b0000, 4'b0010, 1'b1);
    // Downstream not ready holds off the grant.
    step(1'b1, 4'b0001, 4'b0000, 1'b0);
    hold(5, 4'b0001, 4'b0000, 1'b0);
    hold(2, 4'b0001, 4'b0000, 1'b1);
    hold(1, 4'b0000, 4'b0001, 1'b1);
    hold(3, 4'b1000, 4'b0000, 1'b1);
    // Reset mid-packet on input 3, then full contention restarts at input 0.
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    hold(3, 4'b1111, 4'b0000, 1'b1);
    // Tail and expiry in the same cycle: normal release, no error.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    hold(1, 4'b0100, 4'b0000, 1'b1);
    hold(MAXL - 1, 4'b0000, 4'b0000, 1'b1);
    hold(1, 4'b0000, 4'b0100, 1'b1);
    hold(3, 4'b0000, 4'b0000, 1'b1);

    for (int i = 0; i < 500; i++) begin
      r_req  = N'($urandom_range(0, 15));
      r_tail = '0;
      for (int b = 0; b < N; b++) r_tail[b] = ($urandom_range(0, 9) == 0);
      step(($urandom_range(0, 99) == 0), r_req, r_tail, ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
